// File: rtl/tile_seq_controller_pkg.sv
// tile_seq_controller_pkg: shared state encoding and tile-grid sizing helpers
package tile_seq_controller_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CORE  = 3'd2,
    S_WBACK = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;
  function automatic int num_tiles(input int pix, input int tile);
    return (pix + tile - 1) / tile;
  endfunction
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tile_seq_controller_if.sv
// tile_seq_controller_if: start/abort, stage handshakes and status of the tile sequencer
interface tile_seq_controller_if #(
  parameter int RW = 1,
  parameter int CW = 1
);
  logic          start_i;
  logic          abort_i;
  logic          fetch_done_i;
  logic          core_done_i;
  logic          wb_done_i;
  logic          fetch_run_o;
  logic          core_run_o;
  logic          wb_run_o;
  logic [RW-1:0] tile_row_o;
  logic [CW-1:0] tile_col_o;
  logic          busy_o;
  logic          frame_done_o;
  logic          err_o;
  logic [2:0]    state_o;
  logic [2:0]    state_n_o;
  modport master (
    output start_i, abort_i, fetch_done_i, core_done_i, wb_done_i,
    input  fetch_run_o, core_run_o, wb_run_o, tile_row_o, tile_col_o,
           busy_o, frame_done_o, err_o, state_o, state_n_o
  );
  modport slave (
    input  start_i, abort_i, fetch_done_i, core_done_i, wb_done_i,
    output fetch_run_o, core_run_o, wb_run_o, tile_row_o, tile_col_o,
           busy_o, frame_done_o, err_o, state_o, state_n_o
  );
endinterface

// File: rtl/tile_seq_controller_index_counter.sv
// tile_index_counter: row/col tile walker, col fastest, holding on the last tile
module tile_index_counter #(
  parameter int NT_R = 1,
  parameter int NT_C = 1,
  parameter int RW   = 1,
  parameter int CW   = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o
);
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          row_last, col_last, step;
  assign row_last = row_q == RW'(NT_R - 1);
  assign col_last = col_q == CW'(NT_C - 1);
  assign last_o   = row_last && col_last;
  assign step     = adv_i && !last_o;
  // next index: clear wins, otherwise walk the grid unless already on the last tile
  always_comb begin
    col_d = clr_i ? '0 : step ? (col_last ? '0 : col_q + CW'(1)) : col_q;
    row_d = clr_i ? '0 : (step && col_last) ? row_q + RW'(1) : row_q;
  end
  // index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
  assign row_o = row_q;
  assign col_o = col_q;
endmodule

// File: rtl/tile_seq_controller.sv
// tile_seq_controller: per-tile FETCH/CORE/WBACK sequencer with stage timeout and abort
module tile_seq_controller
  import tile_seq_controller_pkg::*;
#(
  parameter int MAX_ROW     = 540,
  parameter int MAX_COL     = 540,
  parameter int TILE_ROWS   = 60,
  parameter int TILE_COLS   = 60,
  parameter int WB_EN       = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input logic                clk,
  input logic                rst,
  tile_seq_controller_if.slave bus
);
  localparam int NT_R = num_tiles(MAX_ROW, TILE_ROWS);
  localparam int NT_C = num_tiles(MAX_COL, TILE_COLS);
  localparam int RW   = idx_width(NT_R);
  localparam int CW   = idx_width(NT_C);
  localparam int TW   = idx_width(TIMEOUT_CYC + 1);
  state_e        state_q, state_d, adv_ns;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          fd_q;
  logic          in_stage, timeout, adv, clr, last;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  assign in_stage = state_q inside {S_FETCH, S_CORE, S_WBACK};
  assign timeout  = TIMEOUT_CYC != 0 && in_stage && cnt_q == TW'(TIMEOUT_CYC - 1);
  assign adv      = !bus.abort_i && ((state_q == S_CORE && bus.core_done_i && WB_EN == 0) ||
                                     (state_q == S_WBACK && bus.wb_done_i));
  assign clr      = bus.abort_i || (bus.start_i && state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign adv_ns   = last ? S_DONE : S_FETCH;
  tile_index_counter #(.NT_R(NT_R), .NT_C(NT_C), .RW(RW), .CW(CW)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr),
    .adv_i (adv),
    .row_o (row),
    .col_o (col),
    .last_o(last)
  );
  // next state: abort beats stage done, stage done beats timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = bus.start_i ? S_FETCH : S_IDLE;
      S_FETCH: state_d = bus.fetch_done_i ? S_CORE : timeout ? S_ERROR : S_FETCH;
      S_CORE:  state_d = bus.core_done_i ? (WB_EN != 0 ? S_WBACK : adv_ns) : timeout ? S_ERROR : S_CORE;
      S_WBACK: state_d = bus.wb_done_i ? adv_ns : timeout ? S_ERROR : S_WBACK;
      S_DONE:  state_d = bus.start_i ? S_FETCH : S_DONE;
      S_ERROR: state_d = bus.start_i ? S_IDLE : S_ERROR;
      default: state_d = S_IDLE;
    endcase
    if (bus.abort_i) state_d = S_IDLE;
  end
  // stage cycle counter restarts on every state change and saturates
  always_comb begin
    cnt_d = (state_d != state_q) ? '0 : (in_stage && cnt_q != '1) ? cnt_q + TW'(1) : cnt_q;
  end
  // state, counter and frame-done pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fd_q    <= state_d == S_DONE && state_q != S_DONE;
    end
  end
  assign bus.fetch_run_o  = state_q == S_FETCH;
  assign bus.core_run_o   = state_q == S_CORE;
  assign bus.wb_run_o     = state_q == S_WBACK;
  assign bus.busy_o       = in_stage;
  assign bus.err_o        = state_q == S_ERROR;
  assign bus.frame_done_o = fd_q;
  assign bus.tile_row_o   = row;
  assign bus.tile_col_o   = col;
  assign bus.state_o      = state_q;
  assign bus.state_n_o    = state_d;
endmodule

// File: tb/tb_tile_seq_controller.sv
// tb_tile_seq_controller: directed checks of three sequencer configurations
module tb_tile_seq_controller;
  import tile_seq_controller_pkg::*;
  logic       clk;
  logic       rst;
  logic       start [3];
  logic       abort [3];
  logic       fdone [3];
  logic       cdone [3];
  logic       wdone [3];
  logic       auto  [3];
  logic [2:0] st    [3];
  logic [2:0] sn    [3];
  logic       fr    [3];
  logic       cr    [3];
  logic       wr    [3];
  logic       bz    [3];
  logic       fd    [3];
  logic       er    [3];
  logic [3:0] trow  [3];
  logic [3:0] tcol  [3];
  int n_chk, n_fail;
  int visits, wbs, fdc, cf, ntile;
  int trec [128];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // instance 0: 8x8/4 WB on, timeout 16; 1: same with WB off; 2: 540x540/60
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int MR = (g == 2) ? 540 : 8;
    localparam int TS = (g == 2) ? 60 : 4;
    localparam int WB = (g == 1) ? 0 : 1;
    localparam int TO = (g == 2) ? 4096 : 16;
    localparam int W  = idx_width(num_tiles(MR, TS));
    int         cyc = 0;
    logic [2:0] ps  = 3'd0;
    logic       fa  = 1'b0;
    logic       ca  = 1'b0;
    logic       wa  = 1'b0;
    tile_seq_controller_if #(.RW(W), .CW(W)) bus ();
    tile_seq_controller #(
      .MAX_ROW(MR), .MAX_COL(MR), .TILE_ROWS(TS), .TILE_COLS(TS),
      .WB_EN(WB), .TIMEOUT_CYC(TO)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    // auto responder: assert the stage's done in its third cycle
    always @(negedge clk) begin
      cyc = (st[g] == ps) ? cyc + 1 : 1;
      ps  = st[g];
      fa  = auto[g] && st[g] == 3'd1 && cyc == 3;
      ca  = auto[g] && st[g] == 3'd2 && cyc == 3;
      wa  = auto[g] && st[g] == 3'd3 && cyc == 3;
    end
    assign bus.start_i      = start[g];
    assign bus.abort_i      = abort[g];
    assign bus.fetch_done_i = fa | fdone[g];
    assign bus.core_done_i  = ca | cdone[g];
    assign bus.wb_done_i    = wa | wdone[g];
    assign st[g]   = bus.state_o;
    assign sn[g]   = bus.state_n_o;
    assign fr[g]   = bus.fetch_run_o;
    assign cr[g]   = bus.core_run_o;
    assign wr[g]   = bus.wb_run_o;
    assign bz[g]   = bus.busy_o;
    assign fd[g]   = bus.frame_done_o;
    assign er[g]   = bus.err_o;
    assign trow[g] = 4'(bus.tile_row_o);
    assign tcol[g] = 4'(bus.tile_col_o);
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // start a frame on instance g and record stage entries until DONE or budget expiry
  task automatic run_frame(input int g, input int budget);
    logic [2:0] p;
    p = st[g];
    visits = 0; wbs = 0; fdc = 0; cf = 0; ntile = 0;
    start[g] = 1'b1;
    for (int i = 0; i < budget && (i == 0 || st[g] != 3'd4); i++) begin
      step(1);
      start[g] = 1'b0;
      if (st[g] != p && st[g] inside {3'd1, 3'd2, 3'd3}) visits++;
      if (st[g] == 3'd1 && p == 3'd2) cf++;
      if (st[g] == 3'd1 && p != 3'd1) begin
        trec[ntile % 128] = int'(trow[g]) * 16 + int'(tcol[g]);
        ntile++;
      end
      wbs += int'(wr[g]);
      fdc += int'(fd[g]);
      p = st[g];
    end
    check("reach_done", int'(st[g]), 4);
  endtask
  initial begin
    int exp4 [4] = '{0, 1, 16, 17};
    int bad;
    int found;
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 0; abort[i] = 0; fdone[i] = 0; cdone[i] = 0; wdone[i] = 0; auto[i] = 0;
    end
    step(2);
    check("rst_state", int'(st[0]), 0);
    check("rst_busy", int'(bz[0]), 0);
    check("rst_err", int'(er[0]), 0);
    check("rst_fd", int'(fd[0]), 0);
    check("rst_runs", int'(fr[0]) + int'(cr[0]) + int'(wr[0]), 0);
    check("rst_row", int'(trow[0]), 0);
    check("rst_col", int'(tcol[0]), 0);
    check("rst_state_c", int'(st[2]), 0);
    rst = 1'b0;
    step(1);
    check("idle_hold", int'(st[0]), 0);
    // 2x2 frame with writeback
    auto[0] = 1'b1;
    run_frame(0, 200);
    check("a_visits", visits, 12);
    check("a_tiles", ntile, 4);
    for (int i = 0; i < 4; i++) check("a_order", trec[i], exp4[i]);
    check("a_core_to_fetch", cf, 0);
    check("a_wb_seen", wbs > 0 ? 1 : 0, 1);
    check("a_fd_first", int'(fd[0]), 1);
    check("a_busy_done", int'(bz[0]), 0);
    check("a_last_row", int'(trow[0]), 1);
    check("a_last_col", int'(tcol[0]), 1);
    step(1);
    check("a_fd_once", int'(fd[0]), 0);
    check("a_done_hold", int'(st[0]), 4);
    auto[0] = 1'b0;
    // 2x2 frame without writeback
    auto[1] = 1'b1;
    run_frame(1, 200);
    check("b_visits", visits, 8);
    check("b_wb_never", wbs, 0);
    check("b_core_to_fetch", cf, 3);
    check("b_fd", fdc, 1);
    for (int i = 0; i < 4; i++) check("b_order", trec[i], exp4[i]);
    auto[1] = 1'b0;
    // 9x9 frame, then restart from DONE
    auto[2] = 1'b1;
    run_frame(2, 3000);
    check("c_tiles", ntile, 81);
    check("c_visits", visits, 243);
    check("c_fd", fdc, 1);
    bad = 0;
    for (int i = 0; i < 81; i++) if (trec[i] != (i / 9) * 16 + i % 9) bad++;
    check("c_order_bad", bad, 0);
    check("c_last_row", int'(trow[2]), 8);
    check("c_last_col", int'(tcol[2]), 8);
    auto[2] = 1'b0;
    start[2] = 1'b1;
    step(1);
    start[2] = 1'b0;
    check("c_restart_state", int'(st[2]), 1);
    check("c_restart_row", int'(trow[2]), 0);
    check("c_restart_col", int'(tcol[2]), 0);
    abort[2] = 1'b1;
    step(1);
    abort[2] = 1'b0;
    check("c_abort_idle", int'(st[2]), 0);
    // fetch-done latency and core-stage timeout on instance 0
    start[0] = 1'b1;
    step(1);
    start[0] = 1'b0;
    check("lat_fetch", int'(fr[0]), 1);
    fdone[0] = 1'b1;
    step(1);
    fdone[0] = 1'b0;
    check("lat_core_run", int'(cr[0]), 1);
    check("lat_fetch_drop", int'(fr[0]), 0);
    step(15);
    check("to_pre_state", int'(st[0]), 2);
    check("to_pre_err", int'(er[0]), 0);
    step(1);
    check("to_state", int'(st[0]), 5);
    check("to_err", int'(er[0]), 1);
    check("to_busy", int'(bz[0]), 0);
    step(3);
    check("to_hold", int'(er[0]), 1);
    start[0] = 1'b1;
    #1;
    check("to_next", int'(sn[0]), 0);
    step(1);
    start[0] = 1'b0;
    check("to_idle", int'(st[0]), 0);
    check("to_err_clr", int'(er[0]), 0);
    // abort together with fetch_done in FETCH of tile (1,0)
    auto[0] = 1'b1;
    start[0] = 1'b1;
    step(1);
    start[0] = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (st[0] == 3'd1 && trow[0] == 4'd1 && tcol[0] == 4'd0) found = 1;
      else step(1);
    end
    check("ab_reach", found, 1);
    auto[0] = 1'b0;
    fdone[0] = 1'b1;
    abort[0] = 1'b1;
    #1;
    check("ab_next", int'(sn[0]), 0);
    step(1);
    fdone[0] = 1'b0;
    abort[0] = 1'b0;
    check("ab_state", int'(st[0]), 0);
    check("ab_row", int'(trow[0]), 0);
    check("ab_col", int'(tcol[0]), 0);
    check("ab_runs", int'(fr[0]) + int'(cr[0]), 0);
    // stray core_done in FETCH, then reset mid-CORE
    start[0] = 1'b1;
    step(1);
    start[0] = 1'b0;
    cdone[0] = 1'b1;
    step(2);
    cdone[0] = 1'b0;
    check("stray_state", int'(st[0]), 1);
    check("stray_fetch", int'(fr[0]), 1);
    fdone[0] = 1'b1;
    step(1);
    fdone[0] = 1'b0;
    step(1);
    check("stray_no_latch", int'(st[0]), 2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mr_state", int'(st[0]), 0);
    check("mr_core", int'(cr[0]), 0);
    check("mr_busy", int'(bz[0]), 0);
    check("mr_err", int'(er[0]), 0);
    check("mr_fd", int'(fd[0]), 0);
    check("mr_idx", int'(trow[0]) + int'(tcol[0]), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
